// File: rtl/mat_pkg.sv
// Shared definitions for the 3x3 fixed-point matrix blocks: Q format,
// saturation limits and the sequencer state encoding.
package mat_pkg;

    localparam int FRAC_BITS = 16;

    localparam logic signed [31:0] Q_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] Q_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mat3_mul_if.sv
// Operand/result bundle for mat3_mul; matrices are row-major, index = row*3 + col.
interface mat3_mul_if;

    logic               start;
    logic signed [31:0] a [9];
    logic signed [31:0] b [9];
    logic               busy;
    logic               done;
    logic               ovf;
    logic signed [31:0] c [9];

    modport master (output start, a, b, input busy, done, ovf, c);
    modport slave  (input start, a, b, output busy, done, ovf, c);

endinterface

// File: rtl/q_shift_sat.sv
// Rescales a 64-bit Q(2*FRAC) accumulator to 32-bit Q(FRAC) with floor
// rounding and saturation to the 32-bit signed range.
module q_shift_sat
    import mat_pkg::*;
#(
    parameter int FRAC = FRAC_BITS
) (
    input  logic signed [63:0] din_i,
    output logic signed [31:0] dout_o,
    output logic               ovf_o
);

    logic signed [63:0] shifted;
    logic               hi_ones;
    logic               hi_zeros;

    always_comb begin
        shifted  = din_i >>> FRAC;
        // The value fits only if bits 63..31 are a pure sign extension.
        hi_ones  = &shifted[63:31];
        hi_zeros = ~|shifted[63:31];
        ovf_o    = !(hi_ones || hi_zeros);
        if (!ovf_o) begin
            dout_o = shifted[31:0];
        end else if (shifted[63]) begin
            dout_o = Q_MIN;
        end else begin
            dout_o = Q_MAX;
        end
    end

endmodule

// File: rtl/mat3_mul.sv
// Sequential 3x3 fixed-point matrix multiply C = A x B using a single
// multiplier, one multiply-accumulate per cycle (27 MAC cycles per result).
module mat3_mul
    import mat_pkg::*;
#(
    parameter int FRAC = FRAC_BITS
) (
    input  logic       clk,
    input  logic       rst,
    mat3_mul_if.slave  bus
);

    state_t             state_q, state_d;
    logic [1:0]         i_q, j_q, k_q;
    logic [1:0]         i_d, j_d, k_d;
    logic signed [63:0] acc_q, acc_d;
    logic               ovf_q;
    logic signed [31:0] a_q [9];
    logic signed [31:0] b_q [9];
    logic signed [31:0] c_q [9];

    logic signed [31:0] a_sel, b_sel;
    logic signed [63:0] prod, sum;
    logic signed [31:0] res;
    logic               res_ovf;
    logic               launch, last;

    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] col);
        return {1'b0, r, 1'b0} + {2'b00, r} + {2'b00, col};
    endfunction

    // Three full-scale products can exceed the 64-bit range; clamping the
    // running sum keeps the sign right so the final result still saturates.
    function automatic logic signed [63:0] sat_add64(input logic signed [63:0] x,
                                                     input logic signed [63:0] y);
        logic signed [63:0] s;
        s = x + y;
        if ((x[63] == y[63]) && (s[63] != x[63])) begin
            return x[63] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}};
        end
        return s;
    endfunction

    assign launch = (state_q == IDLE) && bus.start;
    assign last   = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);
    assign a_sel  = a_q[idx(i_q, k_q)];
    assign b_sel  = b_q[idx(k_q, j_q)];
    assign prod   = $signed({{32{a_sel[31]}}, a_sel}) * $signed({{32{b_sel[31]}}, b_sel});
    assign sum    = sat_add64(acc_q, prod);

    q_shift_sat #(.FRAC(FRAC)) u_scale (
        .din_i  (sum),
        .dout_o (res),
        .ovf_o  (res_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = MAC;
            MAC:     if (last)      state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == MAC);
        bus.done = (state_q == DONE);
    end

    // Loop order: k innermost, then j, then i.
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        acc_d = acc_q;
        if (launch) begin
            i_d   = 2'd0;
            j_d   = 2'd0;
            k_d   = 2'd0;
            acc_d = '0;
        end else if (state_q == MAC) begin
            if (k_q == 2'd2) begin
                k_d   = 2'd0;
                acc_d = '0;
                if (j_q == 2'd2) begin
                    j_d = 2'd0;
                    i_d = (i_q == 2'd2) ? 2'd0 : i_q + 2'd1;
                end else begin
                    j_d = j_q + 2'd1;
                end
            end else begin
                k_d   = k_q + 2'd1;
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q   <= 2'd0;
            j_q   <= 2'd0;
            k_q   <= 2'd0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            for (int n = 0; n < 9; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                c_q[n] <= '0;
            end
        end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            acc_q <= acc_d;
            if (launch) begin
                ovf_q <= 1'b0;
                for (int n = 0; n < 9; n++) begin
                    a_q[n] <= bus.a[n];
                    b_q[n] <= bus.b[n];
                end
            end else if ((state_q == MAC) && (k_q == 2'd2)) begin
                c_q[idx(i_q, j_q)] <= res;
                if (res_ovf) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.c   = c_q;

endmodule

// File: tb/tb_mat3_mul.sv
// Directed bench for mat3_mul: an exact 128-bit reference model feeds a
// scoreboard queue that is drained whenever the DUT pulses done.
module tb_mat3_mul;

    localparam int FRAC = 16;
    localparam logic signed [127:0] QMX = 128'sd2147483647;
    localparam logic signed [127:0] QMN = -128'sd2147483648;

    typedef struct packed {
        logic [287:0] c;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   dc0;
    int   d1, d2;
    exp_t sb [$];
    logic signed [31:0] opa [9];
    logic signed [31:0] opb [9];

    mat3_mul_if bus ();

    mat3_mul #(.FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        logic signed [127:0] s, x, y, sh;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++) begin
                    x = {{96{opa[i*3+k][31]}}, opa[i*3+k]};
                    y = {{96{opb[k*3+j][31]}}, opb[k*3+j]};
                    s = s + x * y;
                end
                sh = s >>> FRAC;
                if (sh > QMX) begin
                    e.c[(i*3+j)*32 +: 32] = 32'h7FFF_FFFF;
                    e.ovf = 1'b1;
                end else if (sh < QMN) begin
                    e.c[(i*3+j)*32 +: 32] = 32'h8000_0000;
                    e.ovf = 1'b1;
                end else begin
                    e.c[(i*3+j)*32 +: 32] = sh[31:0];
                end
            end
        end
        return e;
    endfunction

    task automatic set_all(input logic [31:0] av, input logic [31:0] bv);
        for (int n = 0; n < 9; n++) begin
            opa[n] = av;
            opb[n] = bv;
        end
    endtask

    task automatic set_diag(input logic [31:0] av, input logic [31:0] bv);
        set_all(32'h0, 32'h0);
        for (int n = 0; n < 9; n += 4) begin
            opa[n] = av;
            opb[n] = bv;
        end
    endtask

    task automatic set_rand_small();
        for (int n = 0; n < 9; n++) begin
            opa[n] = 32'($urandom_range(0, 32'h3FFFF));
            opb[n] = 32'($urandom_range(0, 32'h3FFFF));
            if ($urandom_range(0, 1) == 1) opa[n] = -opa[n];
            if ($urandom_range(0, 1) == 1) opb[n] = -opb[n];
        end
    endtask

    task automatic load_ops();
        for (int n = 0; n < 9; n++) begin
            bus.a[n] = opa[n];
            bus.b[n] = opb[n];
        end
    endtask

    task automatic start_op(input bit push);
        load_ops();
        if (push) sb.push_back(model());
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_rise", bus.busy, 32'd1);
        // Operands were captured on the start edge; the bus may now change freely.
        for (int n = 0; n < 9; n++) begin
            bus.a[n] = $urandom;
            bus.b[n] = $urandom;
        end
    endtask

    task automatic compare_res(input string tag);
        exp_t e;
        chk({tag, "_sb_empty"}, 32'(sb.size() == 0), 32'd0);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("%s_c%0d", tag, n), bus.c[n], e.c[n*32 +: 32]);
        end
        chk({tag, "_ovf"}, bus.ovf, 32'(e.ovf));
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int cyc;
        bit seen;
        cyc  = elapsed;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = bus.done;
        end
        chk({tag, "_latency"}, cyc, 32'd27);
        chk({tag, "_busy_at_done"}, bus.busy, 32'd0);
        compare_res(tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, bus.done, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        set_all(32'h0, 32'h0);
        load_ops();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_ovf", bus.ovf, 32'd0);
        chk("rst_c0", bus.c[0], 32'd0);
        chk("rst_c8", bus.c[8], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        set_diag(32'h0001_0000, 32'h0);
        for (int n = 0; n < 9; n++) opb[n] = $urandom;
        start_op(1'b1);
        wait_done("ident", 0);
        for (int n = 0; n < 9; n++) chk($sformatf("ident_eq_b%0d", n), bus.c[n], opb[n]);

        set_diag(32'h0002_0000, 32'h0003_0000);
        start_op(1'b1);
        wait_done("diag", 0);
        chk("diag_c11", bus.c[0], 32'h0006_0000);
        chk("diag_c12", bus.c[1], 32'h0);
        chk("diag_c33", bus.c[8], 32'h0006_0000);

        set_all(32'h0, 32'h0);
        opa[0] = 32'hFFFF_FFFF;
        opb[0] = 32'h0000_0001;
        start_op(1'b1);
        wait_done("floor_neg", 0);
        chk("floor_neg_c11", bus.c[0], 32'hFFFF_FFFF);
        chk("floor_neg_c22", bus.c[4], 32'h0);

        opa[0] = 32'h0000_0001;
        start_op(1'b1);
        wait_done("floor_pos", 0);
        chk("floor_pos_c11", bus.c[0], 32'h0);

        set_all(32'h7FFF_0000, 32'h7FFF_0000);
        start_op(1'b1);
        wait_done("sat_max", 0);
        chk("sat_max_c33", bus.c[8], 32'h7FFF_FFFF);
        chk("sat_max_ovf", bus.ovf, 32'd1);

        set_all(32'h7FFF_0000, 32'h8001_0000);
        start_op(1'b1);
        wait_done("sat_min", 0);
        chk("sat_min_c33", bus.c[8], 32'h8000_0000);
        chk("sat_min_ovf", bus.ovf, 32'd1);

        set_all(32'h8000_0000, 32'h8000_0000);
        start_op(1'b1);
        wait_done("most_neg", 0);
        chk("most_neg_c11", bus.c[0], 32'h7FFF_FFFF);

        set_rand_small();
        start_op(1'b1);
        wait_done("ovf_clear", 0);
        chk("ovf_clear_flag", bus.ovf, 32'd0);

        for (int n = 0; n < 9; n++) begin
            opa[n] = $urandom;
            opb[n] = $urandom;
        end
        start_op(1'b1);
        wait_done("rand_full", 0);

        set_rand_small();
        dc0 = done_cnt;
        start_op(1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignored_start", 5);
        chk("ignored_start_pulses", done_cnt - dc0, 32'd1);

        // start held high: two operations launched 29 cycles apart
        set_rand_small();
        load_ops();
        sb.push_back(model());
        sb.push_back(model());
        d1 = 0;
        d2 = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 29) begin
                chk("b2b_restart_busy", bus.busy, 32'd1);
                bus.start = 1'b0;
            end
            if (bus.done) begin
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
                compare_res("b2b");
            end
        end
        chk("b2b_first_done", d1, 32'd27);
        chk("b2b_second_done", d2, 32'd56);

        set_all(32'h7FFF_0000, 32'h7FFF_0000);
        dc0 = done_cnt;
        start_op(1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_mid_c11", bus.c[0], 32'h7FFF_FFFF);
        chk("abort_mid_ovf", bus.ovf, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 32'd0);
        chk("abort_done", bus.done, 32'd0);
        chk("abort_ovf", bus.ovf, 32'd0);
        chk("abort_c11", bus.c[0], 32'd0);
        chk("abort_c13", bus.c[2], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_rand_small();
        start_op(1'b1);
        wait_done("after_abort", 0);
        chk("after_abort_pulses", done_cnt - dc0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
